// File: rtl/soc_system_mem_pkg.sv
// soc_system_mem_pkg
// Shared definitions for the on-chip dual-port RAM slice.
//   mem_state_e          : fill state machine states (CLEAR, IDLE)
//   READ_LAT_MIN/MAX     : the two supported read latencies
//   clamp_read_latency() : folds a latency parameter onto a supported value
package soc_system_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  // Anything at or below the minimum behaves as a single-stage read,
  // anything above it gets the extra output register stage.
  function automatic int clamp_read_latency(input int lat);
    return (lat <= READ_LAT_MIN) ? READ_LAT_MIN : READ_LAT_MAX;
  endfunction

endpackage

// File: rtl/soc_system_dpram_core.sv
// soc_system_dpram_core
// True dual-port, byte-enabled storage array with one registered read per
// port and no reset. Each byte lane is its own array so that simultaneous
// writes from both ports to one word merge per byte; port A has the final
// say on a byte both ports enable. Reads return the contents from before
// the same edge's writes.
// Ports:
//   clk                : clock
//   a_/b_addr          : word address
//   a_/b_we            : write enable
//   a_/b_be            : per-byte write enables
//   a_/b_wdata         : write data
//   a_/b_rdata         : registered read data (address sampled last edge)
module soc_system_dpram_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  for (genvar lane = 0; lane < NB; lane++) begin : g_lane
    logic [7:0] store [DEPTH];
    logic [7:0] a_q;
    logic [7:0] b_q;

    // Port B is written first so port A's write to the same byte lands last.
    always_ff @(posedge clk) begin
      if (b_we && b_be[lane]) store[b_addr] <= b_wdata[lane*8 +: 8];
      if (a_we && a_be[lane]) store[a_addr] <= a_wdata[lane*8 +: 8];
      a_q <= store[a_addr];
      b_q <= store[b_addr];
    end

    assign a_rdata[lane*8 +: 8] = a_q;
    assign b_rdata[lane*8 +: 8] = b_q;
  end

endmodule

// File: rtl/soc_system_onchip_dpram.sv
// soc_system_onchip_dpram
// Two Avalon-MM slave ports onto one shared RAM, with zero-fill after reset
// or on request, same-cycle cross-port write forwarding and a 1- or 2-cycle
// read pipeline.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   clear_req              : pulse, restarts a whole-array zero-fill
//   init_done              : high when no zero-fill is running
//   s1_/s2_address         : word address
//   s1_/s2_chipselect,
//   s1_/s2_read, _write    : transfer controls
//   s1_/s2_byteenable      : per-byte write enables
//   s1_/s2_writedata       : write data
//   s1_/s2_waitrequest     : high while the fill runs
//   s1_/s2_readdata        : read data, meaningful with readdatavalid
//   s1_/s2_readdatavalid   : one pulse per accepted read
module soc_system_onchip_dpram
  import soc_system_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear_req,
  output logic                init_done,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic                s2_waitrequest,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid
);

  localparam int NB      = DATA_W / 8;
  localparam int EFF_LAT = clamp_read_latency(READ_LATENCY);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  mem_state_e        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              stall_q;
  logic              done_q;

  // Fill state machine. CLEAR walks the counter over every word; a
  // clear_req while filling starts the walk over from address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
      stall_q <= (CLEAR_ON_RESET != 0);
      done_q  <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state)
        CLEAR: begin
          if (clear_req) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            clr_cnt <= '0;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            stall_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign init_done      = done_q;
  assign s1_waitrequest = stall_q;
  assign s2_waitrequest = stall_q;

  // Accepted transfers; read together with write counts as a write only.
  logic s1_wr, s1_rd, s2_wr, s2_rd;
  assign s1_wr = s1_chipselect & s1_write & ~stall_q;
  assign s1_rd = s1_chipselect & s1_read & ~s1_write & ~stall_q;
  assign s2_wr = s2_chipselect & s2_write & ~stall_q;
  assign s2_rd = s2_chipselect & s2_read & ~s2_write & ~stall_q;

  // The fill borrows port B's write path; no transfer is accepted meanwhile.
  logic                clearing;
  logic [ADDR_W-1:0]   b_addr;
  logic                b_we;
  logic [NB-1:0]       b_be;
  logic [DATA_W-1:0]   b_wdata;
  logic [DATA_W-1:0]   a_rdata;
  logic [DATA_W-1:0]   b_rdata;

  assign clearing = (state == CLEAR);
  assign b_addr   = clearing ? clr_cnt : s2_address;
  assign b_we     = clearing | s2_wr;
  assign b_be     = clearing ? '1 : s2_byteenable;
  assign b_wdata  = clearing ? '0 : s2_writedata;

  soc_system_dpram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .a_addr  (s1_address),
    .a_we    (s1_wr),
    .a_be    (s1_byteenable),
    .a_wdata (s1_writedata),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_we    (b_we),
    .b_be    (b_be),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata)
  );

  // The array returns pre-write data when the other port writes the word
  // being read in the same cycle, so capture that write's bytes and patch
  // them over the array output one cycle later.
  logic              rd1_v, rd2_v;
  logic [NB-1:0]     fwd1_mask, fwd2_mask;
  logic [DATA_W-1:0] fwd1_data, fwd2_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1_v     <= 1'b0;
      rd2_v     <= 1'b0;
      fwd1_mask <= '0;
      fwd2_mask <= '0;
      fwd1_data <= '0;
      fwd2_data <= '0;
    end else begin
      rd1_v     <= s1_rd;
      rd2_v     <= s2_rd;
      fwd1_mask <= (s1_rd && s2_wr && (s2_address == s1_address)) ? s2_byteenable : '0;
      fwd2_mask <= (s2_rd && s1_wr && (s1_address == s2_address)) ? s1_byteenable : '0;
      fwd1_data <= s2_writedata;
      fwd2_data <= s1_writedata;
    end
  end

  logic [DATA_W-1:0] merged1, merged2;

  always_comb begin
    merged1 = a_rdata;
    merged2 = b_rdata;
    for (int i = 0; i < NB; i++) begin
      if (fwd1_mask[i]) merged1[i*8 +: 8] = fwd1_data[i*8 +: 8];
      if (fwd2_mask[i]) merged2[i*8 +: 8] = fwd2_data[i*8 +: 8];
    end
  end

  if (EFF_LAT == READ_LAT_MIN) begin : g_lat1
    assign s1_readdatavalid = rd1_v;
    assign s2_readdatavalid = rd2_v;
    assign s1_readdata      = rd1_v ? merged1 : '0;
    assign s2_readdata      = rd2_v ? merged2 : '0;
  end else begin : g_lat2
    logic              out1_v, out2_v;
    logic [DATA_W-1:0] out1_d, out2_d;

    // Extra output stage; the word is frozen here, so a fill starting
    // behind an in-flight read cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out1_v <= 1'b0;
        out2_v <= 1'b0;
        out1_d <= '0;
        out2_d <= '0;
      end else begin
        out1_v <= rd1_v;
        out2_v <= rd2_v;
        out1_d <= rd1_v ? merged1 : '0;
        out2_d <= rd2_v ? merged2 : '0;
      end
    end

    assign s1_readdatavalid = out1_v;
    assign s2_readdatavalid = out2_v;
    assign s1_readdata      = out1_d;
    assign s2_readdata      = out2_d;
  end

endmodule

// File: tb/tb_soc_system_onchip_dpram.sv
// tb_soc_system_onchip_dpram
// Directed and randomized checks of soc_system_onchip_dpram. A 1-cycle
// instance carries most traffic against an array model; a 2-cycle instance
// shares clock, reset and clear_req and checks read pipelining.
module tb_soc_system_onchip_dpram;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_req = 1'b0;

  logic          init_done;
  logic [AW-1:0] s1_address = '0, s2_address = '0;
  logic          s1_chipselect = 0, s1_read = 0, s1_write = 0;
  logic          s2_chipselect = 0, s2_read = 0, s2_write = 0;
  logic [3:0]    s1_byteenable = '0, s2_byteenable = '0;
  logic [31:0]   s1_writedata = '0, s2_writedata = '0;
  logic          s1_waitrequest, s2_waitrequest;
  logic [31:0]   s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid;

  logic          t_init_done;
  logic [AW-1:0] t1_address = '0;
  logic          t1_chipselect = 0, t1_read = 0, t1_write = 0;
  logic [3:0]    t1_byteenable = '0;
  logic [31:0]   t1_writedata = '0;
  logic          t1_waitrequest, t2_waitrequest;
  logic [31:0]   t1_readdata, t2_readdata;
  logic          t1_readdatavalid, t2_readdatavalid;

  always #5 clk = ~clk;

  soc_system_onchip_dpram #(
    .DATA_W(32), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .init_done(init_done),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_waitrequest(s2_waitrequest), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid)
  );

  soc_system_onchip_dpram #(
    .DATA_W(32), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) dut_lat2 (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .init_done(t_init_done),
    .s1_address(t1_address), .s1_chipselect(t1_chipselect), .s1_read(t1_read),
    .s1_write(t1_write), .s1_byteenable(t1_byteenable), .s1_writedata(t1_writedata),
    .s1_waitrequest(t1_waitrequest), .s1_readdata(t1_readdata),
    .s1_readdatavalid(t1_readdatavalid),
    .s2_address('0), .s2_chipselect(1'b0), .s2_read(1'b0),
    .s2_write(1'b0), .s2_byteenable(4'h0), .s2_writedata(32'h0),
    .s2_waitrequest(t2_waitrequest), .s2_readdata(t2_readdata),
    .s2_readdatavalid(t2_readdatavalid)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit mdl_ready = 1'b0;

  // Reference model: the array as a plain word store plus, per port, a
  // queue of reads still owed to the bus with the cycle they are due in.
  logic [31:0] ref_mem [DEPTH];
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;
  rd_t q1[$];
  rd_t q2[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One bus cycle on the 1-cycle instance: drive, update the model, clock,
  // then compare whatever the model says is due this cycle.
  task automatic applyStimulus(
      input logic cs1, input logic rd1, input logic wr1, input logic [AW-1:0] a1,
      input logic [3:0] be1, input logic [31:0] d1,
      input logic cs2, input logic rd2, input logic wr2, input logic [AW-1:0] a2,
      input logic [3:0] be2, input logic [31:0] d2, input logic clr);
    bit w1, r1, w2, r2, ev1, ev2;
    s1_chipselect = cs1; s1_read = rd1; s1_write = wr1; s1_address = a1;
    s1_byteenable = be1; s1_writedata = d1;
    s2_chipselect = cs2; s2_read = rd2; s2_write = wr2; s2_address = a2;
    s2_byteenable = be2; s2_writedata = d2;
    clear_req = clr;
    w1 = mdl_ready && cs1 && wr1;
    r1 = mdl_ready && cs1 && rd1 && !wr1;
    w2 = mdl_ready && cs2 && wr2;
    r2 = mdl_ready && cs2 && rd2 && !wr2;
    // Both writes land in the cycle; s1 has the final word on shared bytes.
    for (int b = 0; b < 4; b++) begin
      if (w2 && be2[b]) ref_mem[a2][b*8 +: 8] = d2[b*8 +: 8];
      if (w1 && be1[b]) ref_mem[a1][b*8 +: 8] = d1[b*8 +: 8];
    end
    // A read returns the word as it stands once this cycle's writes land.
    if (r1) q1.push_back('{cyc + 1, ref_mem[a1]});
    if (r2) q2.push_back('{cyc + 1, ref_mem[a2]});
    @(posedge clk);
    #1;
    cyc++;
    ev1 = (q1.size() > 0) && (q1[0].due == cyc);
    ev2 = (q2.size() > 0) && (q2[0].due == cyc);
    checkOutput("s1_readdatavalid", 32'(s1_readdatavalid), 32'(ev1));
    checkOutput("s2_readdatavalid", 32'(s2_readdatavalid), 32'(ev2));
    if (ev1) begin
      checkOutput("s1_readdata", s1_readdata, q1[0].data);
      void'(q1.pop_front());
    end
    if (ev2) begin
      checkOutput("s2_readdata", s2_readdata, q2[0].data);
      void'(q2.pop_front());
    end
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, 0);
  endtask

  // Counts stalled cycles until the fill ends (bounded), flagging any
  // stalled cycle where init_done or the other port disagree.
  task automatic countStall(output int n, output int bad);
    n = 0;
    bad = 0;
    while (s1_waitrequest === 1'b1 && n < 2000) begin
      if (init_done !== 1'b0 || s2_waitrequest !== 1'b1) bad++;
      idleStep();
      n++;
    end
  endtask

  task automatic zeroModel();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, bad, hi;
    logic [31:0] lat_words [5];

    zeroModel();

    // Reset values of both instances.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    checkOutput("rst_s1_waitrequest", 32'(s1_waitrequest), 32'd1);
    checkOutput("rst_s2_waitrequest", 32'(s2_waitrequest), 32'd1);
    checkOutput("rst_s1_rdv", 32'(s1_readdatavalid), 32'd0);
    checkOutput("rst_s2_rdv", 32'(s2_readdatavalid), 32'd0);
    checkOutput("rst_s1_readdata", s1_readdata, 32'd0);
    checkOutput("rst_s2_readdata", s2_readdata, 32'd0);
    checkOutput("rst_lat2_init_done", 32'(t_init_done), 32'd0);
    checkOutput("rst_lat2_readdata", t1_readdata, 32'd0);

    // Initial fill after release: exactly DEPTH stalled cycles.
    reset_n = 1'b1;
    countStall(n, bad);
    checkOutput("init_fill_cycles", n, DEPTH);
    checkOutput("init_fill_flags", bad, 0);
    checkOutput("init_done_after_fill", 32'(init_done), 32'd1);
    checkOutput("idle_s2_waitrequest", 32'(s2_waitrequest), 32'd0);
    checkOutput("lat2_init_done", 32'(t_init_done), 32'd1);
    mdl_ready = 1'b1;

    // Top word reads back as zero.
    applyStimulus(1, 1, 0, 10'h3FF, 4'h0, '0, 0, 0, 0, '0, '0, '0, 0);
    checkOutput("read_3ff_rdv", 32'(s1_readdatavalid), 32'd1);
    checkOutput("read_3ff_data", s1_readdata, 32'h0000_0000);

    // Partial byte write, read from the other port.
    applyStimulus(1, 0, 1, 10'h010, 4'hF, 32'h1234_5678, 0, 0, 0, '0, '0, '0, 0);
    applyStimulus(1, 0, 1, 10'h010, 4'h2, 32'hAABB_CCDD, 0, 0, 0, '0, '0, '0, 0);
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1, 0, 10'h010, 4'h0, '0, 0);
    checkOutput("be_merge_rdv", 32'(s2_readdatavalid), 32'd1);
    checkOutput("be_merge_data", s2_readdata, 32'h1234_CC78);

    // Dual write collision: s1 owns its enabled bytes.
    applyStimulus(1, 0, 1, 10'h020, 4'h3, 32'h1111_1111, 1, 0, 1, 10'h020, 4'hF, 32'h2222_2222, 0);
    applyStimulus(1, 1, 0, 10'h020, 4'h0, '0, 0, 0, 0, '0, '0, '0, 0);
    checkOutput("collision_data", s1_readdata, 32'h2222_1111);

    // Cross-port forwarding of a same-cycle write.
    applyStimulus(1, 0, 1, 10'h030, 4'hF, 32'hDEAD_BEEF, 1, 1, 0, 10'h030, 4'h0, '0, 0);
    checkOutput("forward_rdv", 32'(s2_readdatavalid), 32'd1);
    checkOutput("forward_data", s2_readdata, 32'hDEAD_BEEF);

    // Read+write together is a write only: no pulse, data stored.
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1, 1, 10'h040, 4'hF, 32'h0BAD_F00D, 0);
    checkOutput("rw_is_write_rdv", 32'(s2_readdatavalid), 32'd0);
    applyStimulus(1, 1, 0, 10'h040, 4'h0, '0, 0, 0, 0, '0, '0, '0, 0);
    checkOutput("rw_is_write_data", s1_readdata, 32'h0BAD_F00D);

    // Randomized traffic on a small window to provoke collisions.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), 10'h100 + 10'($urandom_range(0, 7)),
                    4'($urandom), $urandom,
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), 10'h100 + 10'($urandom_range(0, 7)),
                    4'($urandom), $urandom, 1'b0);
    end
    idleStep();

    // 2-cycle instance: four back-to-back reads, pulses in order.
    for (int i = 1; i <= 4; i++) lat_words[i] = $urandom;
    lat_words[0] = '0;
    t1_chipselect = 1'b1; t1_write = 1'b1; t1_byteenable = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      t1_address = 10'(i);
      t1_writedata = lat_words[i];
      idleStep();
    end
    t1_write = 1'b0;
    t1_read = 1'b1;
    for (int j = 0; j < 7; j++) begin
      bit ev;
      if (j < 4) t1_address = 10'(j + 1);
      else begin
        t1_read = 1'b0;
        t1_chipselect = 1'b0;
      end
      idleStep();
      ev = (j >= 1) && (j <= 4);
      checkOutput("lat2_rdv", 32'(t1_readdatavalid), 32'(ev));
      if (ev) checkOutput("lat2_data", t1_readdata, lat_words[j]);
    end
    checkOutput("lat2_s2_rdv", 32'(t2_readdatavalid), 32'd0);

    // Read accepted alongside clear_req still returns the old word.
    applyStimulus(1, 0, 1, 10'h000, 4'hF, 32'hCAFE_F00D, 0, 0, 0, '0, '0, '0, 0);
    applyStimulus(1, 1, 0, 10'h000, 4'h0, '0, 0, 0, 0, '0, '0, '0, 1);
    checkOutput("preclear_read", s1_readdata, 32'hCAFE_F00D);
    mdl_ready = 1'b0;
    zeroModel();

    // Restart the fill at cycle 500, then reset partway through.
    hi = 0;
    for (int k = 0; k < 500; k++) begin
      if (s1_waitrequest === 1'b1 && init_done === 1'b0) hi++;
      idleStep();
    end
    checkOutput("clear_first_500", hi, 500);
    applyStimulus(0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, 1);
    repeat (300) idleStep();
    checkOutput("clear_restarted_busy", 32'(s1_waitrequest), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midfill_rst_waitrequest", 32'(s2_waitrequest), 32'd1);
    checkOutput("midfill_rst_init_done", 32'(init_done), 32'd0);
    repeat (3) idleStep();
    q1.delete();
    q2.delete();
    reset_n = 1'b1;
    countStall(n, bad);
    checkOutput("final_fill_cycles", n, DEPTH);
    checkOutput("final_fill_flags", bad, 0);
    mdl_ready = 1'b1;

    // Contents are zero again after the refill.
    applyStimulus(1, 1, 0, 10'h010, 4'h0, '0, 1, 1, 0, 10'h3FF, 4'h0, '0, 0);
    checkOutput("post_clear_010", s1_readdata, 32'h0);
    checkOutput("post_clear_3ff", s2_readdata, 32'h0);
    idleStep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/soc_system_onchip_dpram.md
SOC_SYSTEM_ONCHIP_DPRAM -- requirements
Module: soc_system_onchip_dpram

Interface
REQ-001 Parameter DATA_W, default 32: word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10: word address width; DEPTH = 2**ADDR_W.
REQ-003 Parameter READ_LATENCY, default 1: accepted read to readdatavalid, legal values 1 or 2.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the array after reset.
REQ-005 clk  in  1  single clock for both ports and all state.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clear_req  in  1  pulse; starts a zero-fill of the whole array.
REQ-008 init_done  out  1  high when no zero-fill is in progress.
REQ-009 s1_/s2_ address  in  ADDR_W  word address, per port.
REQ-010 s1_/s2_ chipselect, read, write  in  1 each  Avalon-MM slave controls, per port.
REQ-011 s1_/s2_ byteenable  in  DATA_W/8  per-byte write enables.
REQ-012 s1_/s2_ writedata  in  DATA_W  write data.
REQ-013 s1_/s2_ waitrequest  out  1  stall; high during zero-fill.
REQ-014 s1_/s2_ readdata  out  DATA_W  read data, valid only with readdatavalid.
REQ-015 s1_/s2_ readdatavalid  out  1  one-cycle strobe per accepted read.

Function
REQ-016 A port SHALL accept a transfer in any cycle with chipselect=1, (read|write)=1 and waitrequest=0.
REQ-017 An accepted write SHALL update only the bytes whose byteenable bit is 1, at the next clk edge.
REQ-018 An accepted read SHALL assert readdatavalid exactly READ_LATENCY cycles later, one cycle wide, with readdata held to that cycle's word.
REQ-019 Each port SHALL sustain one accepted read per cycle; readdatavalid pulses SHALL be in acceptance order.
REQ-020 read=1 and write=1 together on a port SHALL be treated as a write only; no readdatavalid is produced.
REQ-021 Both ports writing the same address in one cycle: s1 bytes SHALL win wherever s1_byteenable=1; s2 bytes apply elsewhere.
REQ-022 Read on one port and write on the other to the same address in one cycle: the read SHALL return the merged new data (forwarding, byteenable-aware).
REQ-023 Same-port read of an address written in the previous cycle SHALL return the new data.
REQ-024 State machine states: CLEAR, IDLE; reset enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-025 CLEAR: an internal ADDR_W counter SHALL write zero to address 0..DEPTH-1, one word per cycle, using port-2 write resources; counter wraps DEPTH-1 -> IDLE.
REQ-026 CLEAR SHALL last exactly DEPTH cycles; init_done=0 and both waitrequest=1 throughout.
REQ-027 clear_req in IDLE SHALL enter CLEAR on the next cycle with the counter at 0; clear_req in CLEAR SHALL restart the counter at 0.
REQ-028 Reads accepted before entering CLEAR SHALL still complete with readdatavalid at their scheduled cycle; the data returned is the pre-clear value.
REQ-029 In IDLE both waitrequest SHALL be 0; the block never stalls outside CLEAR.

Reset
REQ-030 On reset_n=0: readdatavalid=0, readdata=0, read pipelines flushed, counter=0, state=CLEAR (init_done=0, waitrequest=1) or IDLE (init_done=1, waitrequest=0) per CLEAR_ON_RESET.
REQ-031 Array contents SHALL not be reset asynchronously; reset_n assertion mid-CLEAR restarts the fill from address 0 after release.

Structure
REQ-032 Shared package soc_system_mem_pkg SHALL hold the state enum (CLEAR, IDLE) and the legal READ_LATENCY constants.
REQ-033 One sub-module, soc_system_dpram_core: inferred true dual-port byte-enabled array, one registered read per port, no reset; collision, forwarding, latency and clear logic stay in the top.

Verification (DATA_W=32, ADDR_W=10, READ_LATENCY=1 unless stated)
REQ-034 Release reset, CLEAR_ON_RESET=1 -> waitrequest=1 for 1024 cycles, then init_done=1; s1 read at 0x3FF returns 0x00000000.
REQ-035 s1 write 0x12345678 to 0x010 with byteenable=0xF, then byteenable=0x2 with 0xAABBCCDD -> s2 read of 0x010 returns 0x1234CC78 one cycle after acceptance.
REQ-036 Same cycle s1 write 0x11111111 with byteenable=0x3, s2 write 0x22222222 with byteenable=0xF, both at 0x020 -> readback 0x22221111.
REQ-037 s1 write 0xDEADBEEF to 0x030 while s2 reads 0x030 in the same cycle -> s2_readdata=0xDEADBEEF with readdatavalid next cycle.
REQ-038 READ_LATENCY=2, s1 back-to-back reads of 0x001..0x004 -> four consecutive readdatavalid pulses starting 2 cycles after the first acceptance, in order.
REQ-039 clear_req pulse at cycle 500 of a CLEAR, then reset_n low for 3 cycles mid-fill -> fill restarts each time; total waitrequest duration after final release = 1024 cycles.
